onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Shares the single-port 8192x32 on-chip RAM between two Avalon-MM requesters: requester 0 (CPU data master) and requester 1 (DMA/custom-instruction engine).
- Round-robin arbitration grants at most one access per cycle, and the block tracks the 1-cycle read latency so it can return readdatavalid to the owning requester.
- Contains a clear sequencer that fills the whole RAM with a constant on command, locking out both requesters while it runs.
- Sits between the interconnect and the RAM's address/byteenable/chipselect/write/writedata/clken/readdata pins.

Parameters:
- ADDR_W, 13, word-address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 8192, number of words swept by a clear.
- CLEAR_VALUE, 32'h0000_0000, word written during a clear.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  memory reset request; no accesses are issued while high.
- init_start  in  1  one-cycle pulse that starts a RAM clear.
- init_busy  out  1  high while a clear is in progress.
- init_done  out  1  one-cycle pulse after the last clear write.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_byteenable  in  DATA_W/8  requester 0 byte enables.
- m0_read  in  1  requester 0 read request.
- m0_write  in  1  requester 0 write request.
- m0_writedata  in  DATA_W  requester 0 write data.
- m0_waitrequest  out  1  low only in the cycle requester 0's transfer is accepted.
- m0_readdata  out  DATA_W  requester 0 read data, qualified by m0_readdatavalid.
- m0_readdatavalid  out  1  requester 0 read data valid.
- m1_*  (same set, same widths and meanings)  requester 1.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_chipselect  out  1  RAM chipselect.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; equals ~reset_req.
- mem_readdata  in  DATA_W  RAM q output; valid 1 cycle after the read address is presented.

Behaviour:
- State: FSM {IDLE, CLEAR}; last_grant flop; clr_cnt[ADDR_W-1:0]; rd_pend and rd_owner flops.
- Reset values: FSM=IDLE, last_grant=1 (so requester 0 wins the first tie), clr_cnt=0, rd_pend=0, init_busy=0, init_done=0, both readdatavalid=0, mem_chipselect=0, mem_write=0. While reset is high, both waitrequests are held high.
- A requester is requesting when read|write is high. If read and write are both high, the access is treated as a write and the read is ignored.
- IDLE arbitration (combinational, only when reset_req=0):
  - One requester: it is granted.
  - Both: the requester != last_grant is granted.
  - On a grant, last_grant <= grant.
- Granted requester:
  - Its waitrequest is low in that cycle; the transfer completes that cycle.
  - Its address, byteenable and writedata drive mem_*; mem_chipselect=1; mem_write=its write.
  - The non-granted requester sees waitrequest=1 and must hold its request.
- Idle requester: waitrequest=1 when not requesting. With no grant, mem_chipselect=0 and mem_write=0.
- Read completion:
  - Granted read sets rd_pend<=1 and rd_owner<=grant.
  - Next cycle the owner's readdatavalid=1. The other readdatavalid stays 0.
  - Reads are fully pipelined: back-to-back grants give back-to-back readdatavalid with no bubble.
- mN_readdata = mem_readdata (combinational) for both requesters; readdatavalid is the only qualifier.
- Read-during-write to the same address across consecutive cycles: reads return the newly written data (writes complete in the grant cycle).
- reset_req=1:
  - No grants; both waitrequests high.
  - mem_clken=0; clr_cnt frozen.
  - A read granted in the cycle before reset_req rose still gets its readdatavalid.
- Clear sequence:
  - init_start in IDLE: go to CLEAR, init_busy=1, clr_cnt=0. Any access granted in that same cycle still completes.
  - In CLEAR, each cycle with reset_req=0: mem_address=clr_cnt, mem_writedata=CLEAR_VALUE, byteenable all ones, mem_chipselect=1, mem_write=1, then clr_cnt++.
  - Both waitrequests stay high for the whole clear.
  - After the write to DEPTH-1: go to IDLE; init_busy=0 and a one-cycle init_done pulse in the following cycle; clr_cnt wraps to 0.
  - init_start while in CLEAR is ignored.
  - A clear takes exactly DEPTH cycles when reset_req=0.
- Reset mid-clear: immediately returns to IDLE with clr_cnt=0 and no init_done; RAM contents are undefined.

Test Plan:
- Only m0 reads addr 0x0010 (RAM holds 0xDEADBEEF): m0_waitrequest=0 in cycle N -> m0_readdatavalid=1 with m0_readdata=0xDEADBEEF in N+1; m1_readdatavalid stays 0.
- m0 and m1 both write continuously from reset -> grants alternate 0,1,0,1; each waitrequest is low every other cycle; mem_address alternates between the two addresses.
- m1 writes 0x12345678 to 0x1FFF with byteenable 4'b0011, then m0 reads 0x1FFF (old value 0xAAAAAAAA) -> m0 read returns 0xAAAA5678.
- init_start pulse -> init_busy=1 for 8192 cycles, addresses 0..0x1FFF written with 0, m0/m1 waitrequest high throughout, init_done pulses once; a subsequent read of 0x0ABC returns 0.
- reset_req high for 5 cycles mid-clear -> mem_clken=0, clr_cnt holds, init_busy stays 1, and the clear completes 5 cycles late; reset asserted mid-clear -> init_busy=0 immediately and no init_done.
- Back-to-back m0 reads of 0x0001, 0x0002, 0x0003 with no contention -> readdatavalid high for 3 consecutive cycles with data in order.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
//   Shares one single-port RAM between two Avalon-MM requesters using
//   round-robin arbitration. It tracks the RAM's 1-cycle read latency so
//   that readdatavalid is returned to the requester that owns the read. A
//   clear sequencer can fill the whole RAM with CLEAR_VALUE, and both
//   requesters are locked out while it runs.
//
//   state | meaning
//   IDLE  | arbitrate requesters, at most one RAM access per cycle
//   CLEAR | write CLEAR_VALUE to clr_cnt each enabled cycle, requesters stalled
//
// Ports
//   clk, reset             single clock, asynchronous active-high reset
//   reset_req              memory reset request: no accesses, mem_clken low
//   init_start             one-cycle pulse that starts a RAM clear
//   init_busy, init_done   clear in progress / one-cycle completion pulse
//   m0_*, m1_*             Avalon-MM requester ports (0 = CPU, 1 = DMA)
//   mem_*                  RAM pins; mem_readdata is valid 1 cycle after the address
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH = 8192,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic                init_start,
  output logic                init_busy,
  output logic                init_done,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              rd_pend, rd_pend_nxt;
  logic              rd_owner, rd_owner_nxt;
  logic              init_done_nxt;
  logic              req0, req1, gnt0, gnt1, arb_en;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // reset is used combinationally here so that both waitrequests stay
  // high while reset is asserted, and not only after the next edge.
  assign arb_en = (state == IDLE) && !reset_req && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      clr_cnt    <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      clr_cnt    <= clr_cnt_nxt;
      rd_pend    <= rd_pend_nxt;
      rd_owner   <= rd_owner_nxt;
      init_done  <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    clr_cnt_nxt    = clr_cnt;
    rd_pend_nxt    = 1'b0;
    rd_owner_nxt   = rd_owner;
    init_done_nxt  = 1'b0;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;

    // On a tie, the requester that was not granted last wins.
    if (arb_en) begin
      if (req0 && req1) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end

    case (state)
      IDLE: begin
        if (init_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        if (!reset_req) begin
          mem_address    = clr_cnt;
          mem_byteenable = '1;
          mem_chipselect = 1'b1;
          mem_write      = 1'b1;
          mem_writedata  = CLEAR_VALUE;
          if (clr_cnt == CLR_LAST) begin
            state_nxt     = IDLE;
            clr_cnt_nxt   = '0;
            init_done_nxt = 1'b1;
          end else begin
            clr_cnt_nxt = clr_cnt + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A write takes priority when read and write are both asserted.
    if (gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_writedata  = m0_writedata;
      last_grant_nxt = 1'b0;
      rd_pend_nxt    = m0_read & ~m0_write;
      rd_owner_nxt   = 1'b0;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_writedata  = m1_writedata;
      last_grant_nxt = 1'b1;
      rd_pend_nxt    = m1_read & ~m1_write;
      rd_owner_nxt   = 1'b1;
    end
  end

  assign init_busy        = (state == CLEAR);
  assign mem_clken        = ~reset_req;
  assign m0_waitrequest   = ~gnt0;
  assign m1_waitrequest   = ~gnt1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a behavioural RAM on the mem_* pins, and a
// transaction-level reference model (round-robin owner, a word array and a
// one-deep read-return slot) that predicts every cycle.
module tb_onchip_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          reset, reset_req, init_start;
  logic          init_busy, init_done;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    return 32'h1000_0000 + i * 32'h0001_0003;
  endfunction

  // Behavioural single-port RAM with registered read output
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  assign mem_readdata = ram_q;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else ram_q <= ram[mem_address];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_last;
  logic          ref_busy, ref_done;
  int            ref_cnt;
  logic          exp_v;
  int            exp_own;
  logic [DW-1:0] exp_d;

  int            n_checks = 0;
  int            n_fail = 0;
  logic          obs_busy, obs_done;
  logic [DW-1:0] last_rd0;
  logic [DW-1:0] rd0_hist [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  // Called just after a falling edge with inputs already driven: checks
  // this cycle, advances one rising edge, updates the model, and returns at
  // the next falling edge. g reports the model's grant (-1 = none).
  task automatic step(output int g);
    logic r0, r1, wr;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
    #1;
    if (reset) begin
      ref_busy = 1'b0; ref_done = 1'b0; ref_cnt = 0; ref_last = 1; exp_v = 1'b0;
    end
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g = -1;
    if (!reset && !reset_req && !ref_busy) begin
      if (r0 && r1) g = (ref_last == 0) ? 1 : 0;
      else if (r0) g = 0;
      else if (r1) g = 1;
    end
    check("m0_waitrequest", m0_waitrequest, g != 0);
    check("m1_waitrequest", m1_waitrequest, g != 1);
    check("init_busy", init_busy, ref_busy);
    check("init_done", init_done, ref_done);
    check("mem_clken", mem_clken, !reset_req);
    check("m0_readdatavalid", m0_readdatavalid, exp_v && exp_own == 0);
    check("m1_readdatavalid", m1_readdatavalid, exp_v && exp_own == 1);
    if (exp_v) check("readdata", (exp_own == 0) ? m0_readdata : m1_readdata, exp_d);
    obs_busy = init_busy;
    obs_done = init_done;
    if (m0_readdatavalid) begin
      last_rd0 = m0_readdata;
      rd0_hist.push_back(m0_readdata);
    end
    wr = (g == 0) ? m0_write : m1_write;
    a  = (g == 0) ? m0_address : m1_address;
    be = (g == 0) ? m0_byteenable : m1_byteenable;
    d  = (g == 0) ? m0_writedata : m1_writedata;
    if (g >= 0) begin
      check("grant_cs", mem_chipselect, 1'b1);
      check("grant_addr", mem_address, a);
      check("grant_wr", mem_write, wr);
      if (wr) begin
        check("grant_wdata", mem_writedata, d);
        check("grant_be", mem_byteenable, be);
      end
    end else if (ref_busy && !reset_req) begin
      check("clr_cs", mem_chipselect, 1'b1);
      check("clr_wr", mem_write, 1'b1);
      check("clr_addr", mem_address, ref_cnt);
      check("clr_wdata", mem_writedata, 32'h0);
      check("clr_be", mem_byteenable, 4'hF);
    end else begin
      check("idle_cs", mem_chipselect, 1'b0);
      check("idle_wr", mem_write, 1'b0);
    end
    @(posedge clk);
    ref_done = 1'b0;
    exp_v = 1'b0;
    if (reset) begin
      ref_busy = 1'b0; ref_cnt = 0; ref_last = 1;
    end else begin
      if (g >= 0) begin
        ref_last = g;
        if (wr) ref_mem[a] = merge(ref_mem[a], d, be);
        else begin
          exp_v = 1'b1; exp_own = g; exp_d = ref_mem[a];
        end
      end
      if (ref_busy) begin
        if (!reset_req) begin
          ref_mem[ref_cnt] = 32'h0;
          if (ref_cnt == DEPTH - 1) begin
            ref_busy = 1'b0; ref_done = 1'b1; ref_cnt = 0;
          end else ref_cnt++;
        end
      end else if (init_start) begin
        ref_busy = 1'b1; ref_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_both();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
  endtask

  initial begin
    int g, k, busy_cnt;
    logic a0, a1, seen;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = pat(i);
      ref_mem[i] = pat(i);
    end
    ram[13'h0010] = 32'hDEADBEEF; ref_mem[13'h0010] = 32'hDEADBEEF;
    ram[13'h1FFF] = 32'hAAAAAAAA; ref_mem[13'h1FFF] = 32'hAAAAAAAA;
    ref_last = 1; ref_busy = 0; ref_done = 0; ref_cnt = 0; exp_v = 0; exp_own = 0; exp_d = '0;
    reset = 1'b1; reset_req = 1'b0; init_start = 1'b0;
    idle_both();

    @(negedge clk);
    drive(0, 0, 1, 13'h0100, 4'hF, 32'h0000_1111);
    drive(1, 0, 1, 13'h0200, 4'hF, 32'h0000_2222);
    step(g);
    step(g);
    reset = 1'b0;
    // Continuous contention from reset: requester 0 wins first, then alternate
    for (int i = 0; i < 6; i++) begin
      step(g);
      check("alternate_grant", g, i % 2);
    end
    idle_both();
    step(g);

    // Single uncontended read of 0x0010
    drive(0, 1, 0, 13'h0010, 4'hF, '0);
    step(g);
    idle_both();
    step(g);
    check("read_deadbeef", last_rd0, 32'hDEADBEEF);

    // Partial write by m1 then read by m0
    drive(1, 0, 1, 13'h1FFF, 4'b0011, 32'h12345678);
    step(g);
    idle_both();
    drive(0, 1, 0, 13'h1FFF, 4'hF, '0);
    step(g);
    idle_both();
    step(g);
    check("byteenable_merge", last_rd0, 32'hAAAA5678);

    // Back-to-back reads
    rd0_hist.delete();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, AW'(i), 4'hF, '0);
      step(g);
    end
    idle_both();
    step(g);
    step(g);
    check("b2b_count", rd0_hist.size(), 3);
    for (int i = 0; i < 3 && i < rd0_hist.size(); i++)
      check("b2b_data", rd0_hist[i], pat(i + 1));

    // Full clear with requests held and a 5-cycle reset_req pause
    drive(0, 0, 1, 13'h0005, 4'hF, 32'h5555_5555);
    drive(1, 1, 0, 13'h0006, 4'hF, '0);
    init_start = 1'b1;
    step(g);
    init_start = 1'b0;
    busy_cnt = 0; seen = 1'b0;
    for (k = 0; k < 9000 && !seen; k++) begin
      reset_req = (k >= 100 && k < 105);
      if (k == 200) init_start = 1'b1;
      else init_start = 1'b0;
      step(g);
      if (obs_busy) busy_cnt++;
      if (obs_done) seen = 1'b1;
    end
    reset_req = 1'b0;
    init_start = 1'b0;
    check("clear_done_seen", seen, 1'b1);
    check("clear_length", busy_cnt, DEPTH + 5);
    idle_both();
    step(g);
    step(g);
    drive(0, 1, 0, 13'h0ABC, 4'hF, '0);
    step(g);
    idle_both();
    step(g);
    check("read_after_clear", last_rd0, 32'h0);

    // Reset mid-clear
    init_start = 1'b1;
    step(g);
    init_start = 1'b0;
    for (int i = 0; i < 50; i++) step(g);
    reset = 1'b1;
    step(g);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(g);
    // Contents are undefined after an interrupted clear; resync RAM and model
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = pat(i);
      ref_mem[i] = pat(i);
    end

    // Randomized traffic with occasional reset_req
    a0 = 1'b0; a1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!a0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 3);
        drive(0, k != 1, k >= 1 && k <= 2, AW'($urandom_range(0, 15)), BW'($urandom), $urandom);
        a0 = 1'b1;
      end
      if (!a1 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 3);
        drive(1, k != 1, k >= 1 && k <= 2, AW'($urandom_range(0, 15)), BW'($urandom), $urandom);
        a1 = 1'b1;
      end
      reset_req = ($urandom_range(0, 15) == 0);
      step(g);
      if (g == 0) begin drive(0, 0, 0, '0, '0, '0); a0 = 1'b0; end
      if (g == 1) begin drive(1, 0, 0, '0, '0, '0); a1 = 1'b0; end
    end
    reset_req = 1'b0;
    idle_both();
    step(g);
    step(g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
